// File: rtl/arm_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arm_ctrl_pkg : shared types/encodings for the multicycle ARM control |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } statetype;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // flags are packed {N, Z, C, V}; the reserved code 1111 never executes
    function automatic logic cond_ex(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cond_unit : NZCV register, condition evaluation and write gating     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cond_unit
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       latch_cond,
    input  logic       flag_en,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] flags
);

    logic cond_ex_r;

    // condition is sampled once in DECODE so later flag writes cannot affect it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags     <= RESET_FLAGS;
            cond_ex_r <= 1'b0;
        end else begin
            if (latch_cond)
                cond_ex_r <= cond_ex(Cond, flags);
            if (flag_en && cond_ex_r) begin
                if (FlagW[1])
                    flags[3:2] <= ALUFlags[3:2];
                if (FlagW[0])
                    flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    assign PCWrite  = reset_n & (NextPC | (PCS & cond_ex_r));
    assign RegWrite = reset_n & RegW & cond_ex_r & ~NoWrite;
    assign MemWrite = reset_n & MemW & cond_ex_r;

endmodule
`default_nettype wire

// File: rtl/arm_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arm_multicycle_ctrl : main FSM and ALU decode for multicycle ARM     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Illegal
);

    statetype state, state_n;
    logic ir_write, next_pc, branch, reg_w, mem_w, alu_op;
    logic is_add, is_sub, is_cmp, is_tst, dp_bad;
    logic [1:0] dp_ctrl;
    logic [1:0] flag_w;
    logic no_write, pcs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= FETCH;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        ir_write  = 1'b0;
        next_pc   = 1'b0;
        branch    = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        case (state)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_write  = 1'b1;
                next_pc   = 1'b1;
                state_n   = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (Op)
                    2'b00:   state_n = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_n = MEMADR;
                    2'b10:   state_n = BRANCH;
                    default: state_n = UNKNOWN;
                endcase
            end
            MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_n = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_n = MEMWB;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
                state_n   = FETCH;
            end
            MEMWR: begin
                AdrSrc  = 1'b1;
                mem_w   = 1'b1;
                state_n = FETCH;
            end
            EXECUTER: begin
                ALUSrcB = SRCB_REG;
                alu_op  = 1'b1;
                state_n = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                alu_op  = 1'b1;
                state_n = ALUWB;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                reg_w     = 1'b1;
                state_n   = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
                state_n   = FETCH;
            end
            default: state_n = UNKNOWN;
        endcase
    end

    // classification is per instruction so ALUWB can still suppress CMP/TST
    always_comb begin
        is_add  = 1'b0;
        is_sub  = 1'b0;
        is_cmp  = 1'b0;
        is_tst  = 1'b0;
        dp_bad  = 1'b0;
        dp_ctrl = ALU_ADD;
        case (Funct[4:1])
            4'b0100: begin dp_ctrl = ALU_ADD; is_add = 1'b1; end
            4'b0010: begin dp_ctrl = ALU_SUB; is_sub = 1'b1; end
            4'b0000: dp_ctrl = ALU_AND;
            4'b1100: dp_ctrl = ALU_ORR;
            4'b1010: begin dp_ctrl = ALU_SUB; is_cmp = 1'b1; end
            4'b1000: begin dp_ctrl = ALU_AND; is_tst = 1'b1; end
            default: dp_bad = 1'b1;
        endcase
    end

    assign ALUControl = alu_op ? dp_ctrl : ALU_ADD;
    assign flag_w[1]  = Funct[0] & alu_op;
    assign flag_w[0]  = flag_w[1] & (is_add | is_sub | is_cmp);
    assign no_write   = (Op == 2'b00) & (is_cmp | is_tst | dp_bad);
    assign pcs        = ((Rd == 4'd15) & reg_w) | branch;

    assign IRWrite = ir_write & reset_n;
    assign ImmSrc  = Op;
    assign RegSrc  = {Op == 2'b10, Op == 2'b01};
    assign Illegal = (state == UNKNOWN);

    cond_unit #(
        .RESET_FLAGS (RESET_FLAGS)
    ) u_cond (
        .clk        (clk),
        .reset_n    (reset_n),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .FlagW      (flag_w),
        .latch_cond (state == DECODE),
        .flag_en    (alu_op),
        .PCS        (pcs),
        .NextPC     (next_pc),
        .RegW       (reg_w),
        .MemW       (mem_w),
        .NoWrite    (no_write),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .flags      ()
    );

endmodule
`default_nettype wire

// File: tb/tb_arm_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_arm_multicycle_ctrl : directed self-checking bench                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_arm_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       IRWrite, AdrSrc, ALUSrcA, PCWrite, RegWrite, MemWrite, Illegal;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

    int n_assert = 0;
    int n_fail   = 0;

    arm_multicycle_ctrl #(.RESET_FLAGS(4'b0000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // check the enables for the current cycle, then move to the next negedge
    task automatic cyc(input string tag, input logic irw, input logic pcw,
                       input logic rw, input logic mw, input logic ill);
        chk({tag, "/IRWrite"},  {3'b0, IRWrite},  {3'b0, irw});
        chk({tag, "/PCWrite"},  {3'b0, PCWrite},  {3'b0, pcw});
        chk({tag, "/RegWrite"}, {3'b0, RegWrite}, {3'b0, rw});
        chk({tag, "/MemWrite"}, {3'b0, MemWrite}, {3'b0, mw});
        chk({tag, "/Illegal"},  {3'b0, Illegal},  {3'b0, ill});
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o,
                             input logic [5:0] f, input logic [3:0] r, input logic [3:0] af);
        Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = af;
        #1;
    endtask

    task automatic fetch_decode(input string tag);
        chk({tag, "/F.ALUSrcA"},   {3'b0, ALUSrcA}, 4'h1);
        chk({tag, "/F.ALUSrcB"},   {2'b0, ALUSrcB}, 4'h2);
        chk({tag, "/F.ResultSrc"}, {2'b0, ResultSrc}, 4'h2);
        chk({tag, "/F.AdrSrc"},    {3'b0, AdrSrc}, 4'h0);
        cyc({tag, "/F"}, 1, 1, 0, 0, 0);
        chk({tag, "/D.ALUSrcB"},   {2'b0, ALUSrcB}, 4'h2);
        cyc({tag, "/D"}, 0, 0, 0, 0, 0);
    endtask

    // data-processing: FETCH, DECODE, EXECUTE, ALUWB
    task automatic run_dp(input string tag, input logic [3:0] c, input logic [5:0] f,
                          input logic [3:0] r, input logic [3:0] af,
                          input logic [1:0] exp_ctrl, input logic exp_rw, input logic exp_pcw);
        set_instr(c, 2'b00, f, r, af);
        fetch_decode(tag);
        chk({tag, "/E.ALUSrcB"},    {2'b0, ALUSrcB}, f[5] ? 4'h1 : 4'h0);
        chk({tag, "/E.ALUControl"}, {2'b0, ALUControl}, {2'b0, exp_ctrl});
        cyc({tag, "/E"}, 0, 0, 0, 0, 0);
        chk({tag, "/WB.ResultSrc"}, {2'b0, ResultSrc}, 4'h0);
        cyc({tag, "/WB"}, 0, exp_pcw, exp_rw, 0, 0);
    endtask

    task automatic run_branch(input string tag, input logic [3:0] c, input logic taken);
        set_instr(c, 2'b10, 6'b100000, 4'd0, 4'b0000);
        fetch_decode(tag);
        chk({tag, "/B.ALUSrcB"},   {2'b0, ALUSrcB}, 4'h1);
        chk({tag, "/B.ResultSrc"}, {2'b0, ResultSrc}, 4'h2);
        cyc({tag, "/B"}, 0, taken, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        set_instr(4'b1110, 2'b00, 6'b001000, 4'd1, 4'b0000);
        reset_n = 1'b0;
        #1;
        chk("rst/IRWrite", {3'b0, IRWrite}, 4'h0);
        chk("rst/PCWrite", {3'b0, PCWrite}, 4'h0);
        chk("rst/Illegal", {3'b0, Illegal}, 4'h0);
        chk("rst/ALUSrcB", {2'b0, ALUSrcB}, 4'h2);
        chk("rst/ALUSrcA", {3'b0, ALUSrcA}, 4'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // 1. ADD R1, immediate
        run_dp("add", 4'b1110, 6'b001000, 4'd1, 4'b0000, 2'b00, 1, 0);
        chk("add/ImmSrc", {2'b0, ImmSrc}, 4'h0);

        // 2. SUBS register sets Z and C, then BEQ taken
        run_dp("subs", 4'b1110, 6'b000101, 4'd2, 4'b0110, 2'b01, 1, 0);
        chk("subs/flags", dut.u_cond.flags, 4'b0110);
        run_branch("beq_t", 4'b0000, 1);

        // 3. ADDS clears flags; BEQ not taken, BNE taken
        run_dp("adds", 4'b1110, 6'b001001, 4'd3, 4'b0000, 2'b00, 1, 0);
        chk("adds/flags", dut.u_cond.flags, 4'b0000);
        run_branch("beq_nt", 4'b0000, 0);
        run_branch("bne_t", 4'b0001, 1);

        // 4. LDR into PC, then STR
        set_instr(4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000);
        chk("ldr/RegSrc", {2'b0, RegSrc}, 4'h1);
        fetch_decode("ldr");
        chk("ldr/MA.ALUSrcB", {2'b0, ALUSrcB}, 4'h1);
        cyc("ldr/MA", 0, 0, 0, 0, 0);
        chk("ldr/MR.AdrSrc", {3'b0, AdrSrc}, 4'h1);
        cyc("ldr/MR", 0, 0, 0, 0, 0);
        chk("ldr/MWB.ResultSrc", {2'b0, ResultSrc}, 4'h1);
        cyc("ldr/MWB", 0, 1, 1, 0, 0);
        set_instr(4'b1110, 2'b01, 6'b011000, 4'd4, 4'b0000);
        fetch_decode("str");
        cyc("str/MA", 0, 0, 0, 0, 0);
        chk("str/MW.AdrSrc", {3'b0, AdrSrc}, 4'h1);
        cyc("str/MW", 0, 0, 0, 1, 0);

        // 5. CMP / TST never write; TST leaves C,V alone even with C,V set on the ALU
        run_dp("cmp", 4'b1110, 6'b010101, 4'd0, 4'b1000, 2'b01, 0, 0);
        chk("cmp/flags", dut.u_cond.flags, 4'b1000);
        run_dp("tst", 4'b1110, 6'b010001, 4'd0, 4'b0111, 2'b10, 0, 0);
        chk("tst/flags", dut.u_cond.flags, 4'b0100);
        run_branch("beq_z", 4'b0000, 1);
        run_branch("bmi_nt", 4'b0100, 0);
        run_dp("addne_pc", 4'b0001, 6'b101000, 4'd15, 4'b0000, 2'b00, 0, 0);
        run_dp("eor_bad", 4'b1110, 6'b000010, 4'd5, 4'b0000, 2'b00, 0, 0);
        run_dp("orr", 4'b1110, 6'b011000, 4'd6, 4'b0000, 2'b11, 1, 0);
        run_dp("nv", 4'b1111, 6'b001000, 4'd7, 4'b0000, 2'b00, 0, 0);
        run_dp("add_pc", 4'b1110, 6'b101000, 4'd15, 4'b0000, 2'b00, 1, 1);

        // 6. undefined Op: sticky UNKNOWN, then async reset mid-cycle
        set_instr(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000);
        fetch_decode("undef");
        for (int i = 0; i < 10; i++)
            cyc($sformatf("undef/U%0d", i), 0, 0, 0, 0, 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst/IRWrite", {3'b0, IRWrite}, 4'h0);
        chk("arst/PCWrite", {3'b0, PCWrite}, 4'h0);
        chk("arst/Illegal", {3'b0, Illegal}, 4'h0);
        chk("arst/ALUSrcB", {2'b0, ALUSrcB}, 4'h2);
        @(negedge clk);
        reset_n = 1'b1;
        run_dp("post_rst", 4'b1110, 6'b001000, 4'd1, 4'b0000, 2'b00, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
